// File: rtl/rx_byte_packer.sv
// rtl/rx_byte_packer.sv - packs a byte stream into OUT_BYTES-wide words with keep/last/user
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   rx_axis_mac_t*             8-bit input byte stream (tdata/tvalid/tlast/tuser, tready out)
//   rx_axis_t*                 packed output word stream (tdata/tkeep/tvalid/tlast/tuser, tready in)
//   frame_count, err_count     delivered frames / delivered frames flagged with tuser
module rx_byte_packer #(
    parameter int OUT_BYTES   = 8,
    parameter int USER_STICKY = 1,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_axis_mac_tdata,
    input  logic                   rx_axis_mac_tvalid,
    input  logic                   rx_axis_mac_tlast,
    input  logic                   rx_axis_mac_tuser,
    output logic                   rx_axis_mac_tready,
    output logic [8*OUT_BYTES-1:0] rx_axis_tdata,
    output logic [OUT_BYTES-1:0]   rx_axis_tkeep,
    output logic                   rx_axis_tvalid,
    output logic                   rx_axis_tlast,
    output logic                   rx_axis_tuser,
    input  logic                   rx_axis_tready,
    output logic [CNT_W-1:0]       frame_count,
    output logic [CNT_W-1:0]       err_count
);
    localparam int LW = $clog2(OUT_BYTES);
    localparam logic [LW-1:0] LAST_LANE = LW'(OUT_BYTES - 1);

    logic [8*OUT_BYTES-1:0] acc_data;
    logic [OUT_BYTES-1:0]   acc_keep;
    logic [LW-1:0]          lane_cnt;
    logic                   sticky;
    logic                   accept;
    logic                   commit;
    logic [8*OUT_BYTES-1:0] word_data;
    logic [OUT_BYTES-1:0]   word_keep;
    logic                   word_user;

    // The output register is the only storage stage, so input is accepted
    // whenever that register is empty or being drained this cycle.
    assign rx_axis_mac_tready = !rx_axis_tvalid || rx_axis_tready;
    assign accept             = rx_axis_mac_tvalid && rx_axis_mac_tready;
    assign commit             = accept && (rx_axis_mac_tlast || lane_cnt == LAST_LANE);

    // Word presented to the output register on commit: accumulated lanes plus
    // the completing byte; lanes never written in this word read as zero.
    always_comb begin
        word_data = '0;
        word_keep = acc_keep;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (k == int'(lane_cnt)) begin
                word_data[8*k +: 8] = rx_axis_mac_tdata;
                word_keep[k]        = 1'b1;
            end else if (acc_keep[k]) begin
                word_data[8*k +: 8] = acc_data[8*k +: 8];
            end
        end
        if (!rx_axis_mac_tlast) begin
            word_user = 1'b0;
        end else if (USER_STICKY != 0) begin
            word_user = sticky | rx_axis_mac_tuser;
        end else begin
            word_user = rx_axis_mac_tuser;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_data <= '0;
            acc_keep <= '0;
            lane_cnt <= '0;
            sticky   <= 1'b0;
        end else if (accept) begin
            if (commit) begin
                // Stale acc_data is masked by the cleared keep bits.
                acc_keep <= '0;
                lane_cnt <= '0;
                sticky   <= rx_axis_mac_tlast ? 1'b0 : (sticky | rx_axis_mac_tuser);
            end else begin
                acc_data[8*lane_cnt +: 8] <= rx_axis_mac_tdata;
                acc_keep[lane_cnt]        <= 1'b1;
                lane_cnt                  <= lane_cnt + LW'(1);
                sticky                    <= sticky | rx_axis_mac_tuser;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_axis_tdata  <= '0;
            rx_axis_tkeep  <= '0;
            rx_axis_tvalid <= 1'b0;
            rx_axis_tlast  <= 1'b0;
            rx_axis_tuser  <= 1'b0;
            frame_count    <= '0;
            err_count      <= '0;
        end else begin
            if (commit) begin
                rx_axis_tdata  <= word_data;
                rx_axis_tkeep  <= word_keep;
                rx_axis_tvalid <= 1'b1;
                rx_axis_tlast  <= rx_axis_mac_tlast;
                rx_axis_tuser  <= word_user;
            end else if (rx_axis_tready) begin
                rx_axis_tvalid <= 1'b0;
            end
            if (rx_axis_tvalid && rx_axis_tready && rx_axis_tlast) begin
                frame_count <= frame_count + CNT_W'(1);
                err_count   <= err_count + {{(CNT_W-1){1'b0}}, rx_axis_tuser};
            end
        end
    end
endmodule

// File: tb/tb_rx_byte_packer.sv
// tb/tb_rx_byte_packer.sv - randomized self-checking bench for rx_byte_packer
module tb_rx_byte_packer;
    logic clk, rst;
    int   n_chk = 0;
    int   n_fail = 0;

    // Stream A drives two 8-byte packers (sticky and non-sticky user) in lockstep.
    logic [7:0]  a_data;
    logic        a_valid, a_last, a_user, a_tready;
    logic        a_rdy_s, a_rdy_n;
    logic [63:0] s_tdata, n_tdata;
    logic [7:0]  s_tkeep, n_tkeep;
    logic        s_tvalid, s_tlast, s_tuser, n_tvalid, n_tlast, n_tuser;
    logic [15:0] s_fc, s_ec, n_fc, n_ec;

    // Stream B drives a 4-byte packer for the long random run.
    logic [7:0]  b_data;
    logic        b_valid, b_last, b_user, b_tready, b_rdy;
    logic [31:0] q_tdata;
    logic [3:0]  q_tkeep;
    logic        q_tvalid, q_tlast, q_tuser;
    logic [15:0] q_fc, q_ec;

    rx_byte_packer #(.OUT_BYTES(8), .USER_STICKY(1), .CNT_W(16)) u8s (
        .clk(clk), .reset(rst),
        .rx_axis_mac_tdata(a_data), .rx_axis_mac_tvalid(a_valid), .rx_axis_mac_tlast(a_last),
        .rx_axis_mac_tuser(a_user), .rx_axis_mac_tready(a_rdy_s),
        .rx_axis_tdata(s_tdata), .rx_axis_tkeep(s_tkeep), .rx_axis_tvalid(s_tvalid),
        .rx_axis_tlast(s_tlast), .rx_axis_tuser(s_tuser), .rx_axis_tready(a_tready),
        .frame_count(s_fc), .err_count(s_ec));

    rx_byte_packer #(.OUT_BYTES(8), .USER_STICKY(0), .CNT_W(16)) u8n (
        .clk(clk), .reset(rst),
        .rx_axis_mac_tdata(a_data), .rx_axis_mac_tvalid(a_valid), .rx_axis_mac_tlast(a_last),
        .rx_axis_mac_tuser(a_user), .rx_axis_mac_tready(a_rdy_n),
        .rx_axis_tdata(n_tdata), .rx_axis_tkeep(n_tkeep), .rx_axis_tvalid(n_tvalid),
        .rx_axis_tlast(n_tlast), .rx_axis_tuser(n_tuser), .rx_axis_tready(a_tready),
        .frame_count(n_fc), .err_count(n_ec));

    rx_byte_packer #(.OUT_BYTES(4), .USER_STICKY(1), .CNT_W(16)) u4 (
        .clk(clk), .reset(rst),
        .rx_axis_mac_tdata(b_data), .rx_axis_mac_tvalid(b_valid), .rx_axis_mac_tlast(b_last),
        .rx_axis_mac_tuser(b_user), .rx_axis_mac_tready(b_rdy),
        .rx_axis_tdata(q_tdata), .rx_axis_tkeep(q_tkeep), .rx_axis_tvalid(q_tvalid),
        .rx_axis_tlast(q_tlast), .rx_axis_tuser(q_tuser), .rx_axis_tready(b_tready),
        .frame_count(q_fc), .err_count(q_ec));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Words accepted on stream A (captured at the negedge preceding the accepting edge).
    logic [63:0] wq_data[$];
    logic [7:0]  wq_keep[$];
    logic        wq_last[$], wq_us[$], wq_un[$];

    initial forever begin
        @(negedge clk);
        if (s_tvalid === 1'b1 && a_tready === 1'b1) begin
            wq_data.push_back(s_tdata);
            wq_keep.push_back(s_tkeep);
            wq_last.push_back(s_tlast);
            wq_us.push_back(s_tuser);
            wq_un.push_back(n_tuser);
        end
    end

    // Stream B reassembly: bytes, frame lengths, frame error flags, protocol violations.
    logic [7:0] got_b_bytes[$];
    int         got_b_lens[$];
    logic       got_b_user[$];
    int         cur_b_len = 0;
    int         keep_err = 0;
    int         stab_err = 0;
    logic       prev_stall = 1'b0;
    logic [37:0] prev_word = '0;

    initial forever begin
        @(negedge clk);
        if (prev_stall && (q_tvalid !== 1'b1 || {q_tdata, q_tkeep, q_tlast, q_tuser} !== prev_word))
            stab_err++;
        prev_stall = (q_tvalid === 1'b1 && b_tready === 1'b0);
        prev_word  = {q_tdata, q_tkeep, q_tlast, q_tuser};
        if (q_tvalid === 1'b1 && b_tready === 1'b1) begin
            if (q_tkeep == 4'd0 || (q_tkeep & (q_tkeep + 4'd1)) != 4'd0) keep_err++;
            if (!q_tlast && q_tkeep != 4'hF) keep_err++;
            if (!q_tlast && q_tuser) keep_err++;
            for (int k = 0; k < 4; k++) begin
                if (q_tkeep[k]) begin
                    got_b_bytes.push_back(q_tdata[8*k +: 8]);
                    cur_b_len++;
                end else if (q_tdata[8*k +: 8] != 8'd0) begin
                    keep_err++;
                end
            end
            if (q_tlast) begin
                got_b_lens.push_back(cur_b_len);
                got_b_user.push_back(q_tuser);
                cur_b_len = 0;
            end
        end
    end

    function automatic logic [63:0] pack8(input logic [7:0] d[16], input int start, input int n);
        logic [63:0] w = '0;
        for (int i = 0; i < n; i++) w = w | (64'(d[start+i]) << (8*i));
        return w;
    endfunction

    task automatic clear_a();
        wq_data.delete(); wq_keep.delete(); wq_last.delete(); wq_us.delete(); wq_un.delete();
    endtask

    // Present one byte on stream A and return one cycle after it is accepted.
    task automatic send_a(input logic [7:0] d, input logic l, input logic u);
        int w = 0;
        a_data = d; a_last = l; a_user = u; a_valid = 1'b1;
        @(negedge clk);
        while (a_rdy_s !== 1'b1 && w < 200) begin
            w++;
            @(negedge clk);
        end
        n_chk++;
        if (a_rdy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL send_a_timeout: mac_tready %b after %0d cycles, required 1", a_rdy_s, w);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0; a_user = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic l, input logic u);
        int w = 0;
        b_data = d; b_last = l; b_user = u; b_valid = 1'b1;
        @(negedge clk);
        while (b_rdy !== 1'b1 && w < 200) begin
            w++;
            @(negedge clk);
        end
        n_chk++;
        if (b_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL send_b_timeout: mac_tready %b after %0d cycles, required 1", b_rdy, w);
        end
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0; b_user = 1'b0;
    endtask

    int exp_fc = 0, exp_es = 0, exp_en = 0;

    task automatic test_reset();
        rst = 1'b1;
        a_data = '0; a_valid = 1'b0; a_last = 1'b0; a_user = 1'b0; a_tready = 1'b0;
        b_data = '0; b_valid = 1'b0; b_last = 1'b0; b_user = 1'b0; b_tready = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({s_tvalid, s_tlast, s_tuser, s_tkeep, s_tdata} !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v%b l%b u%b k%h d%h, required all 0", s_tvalid, s_tlast, s_tuser, s_tkeep, s_tdata);
        end
        n_chk++;
        if ({s_fc, s_ec, q_fc, q_ec} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %h %h %h %h, required 0", s_fc, s_ec, q_fc, q_ec);
        end
        n_chk++;
        if ({a_rdy_s, a_rdy_n, b_rdy} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_mac_tready: got %b, required 111 with downstream tready=0", {a_rdy_s, a_rdy_n, b_rdy});
        end
        @(posedge clk); #1;
        rst = 1'b0; a_tready = 1'b1; b_tready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_rdy_s, b_rdy, s_tvalid} !== 3'b110) begin
            n_fail++;
            $display("FAIL post_reset_ready: got rdy %b%b tvalid %b, required 11 0", a_rdy_s, b_rdy, s_tvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_two_words();
        logic [7:0] d[16];
        time t0;
        clear_a();
        for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
        t0 = $time;
        for (int i = 0; i < 16; i++) send_a(d[i], i == 15, 1'b0);
        n_chk++;
        if ($time - t0 != 160) begin
            n_fail++;
            $display("FAIL back_to_back_rate: took %0t, required 160 (one byte per cycle)", $time - t0);
        end
        repeat (2) @(posedge clk); #1;
        exp_fc++;
        n_chk++;
        if (wq_data.size() != 2) begin
            n_fail++;
            $display("FAIL two_words_count: got %0d words, required 2", wq_data.size());
        end else begin
            n_chk++;
            if ({wq_data[0], wq_keep[0], wq_last[0]} !== {64'h0807060504030201, 8'hFF, 1'b0}) begin
                n_fail++;
                $display("FAIL two_words_w0: got %h k%h l%b, required 0807060504030201 kFF l0", wq_data[0], wq_keep[0], wq_last[0]);
            end
            n_chk++;
            if ({wq_data[1], wq_keep[1], wq_last[1]} !== {64'h100F0E0D0C0B0A09, 8'hFF, 1'b1}) begin
                n_fail++;
                $display("FAIL two_words_w1: got %h k%h l%b, required 100F0E0D0C0B0A09 kFF l1", wq_data[1], wq_keep[1], wq_last[1]);
            end
        end
        n_chk++;
        if (s_fc !== 16'(exp_fc)) begin
            n_fail++;
            $display("FAIL two_words_frame_count: got %0d, required %0d", s_fc, exp_fc);
        end
    endtask

    task automatic test_partial();
        send_a(8'hAA, 1'b0, 1'b0);
        send_a(8'hBB, 1'b0, 1'b0);
        a_data = 8'hCC; a_last = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if (s_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_early_valid: tvalid %b before CC accepted, required 0", s_tvalid);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; a_last = 1'b0;
        n_chk++;
        if ({s_tvalid, s_tdata, s_tkeep, s_tlast} !== {1'b1, 64'h0000000000CCBBAA, 8'h07, 1'b1}) begin
            n_fail++;
            $display("FAIL partial_word: got v%b %h k%h l%b, required v1 0000000000CCBBAA k07 l1", s_tvalid, s_tdata, s_tkeep, s_tlast);
        end
        @(posedge clk); #1;
        exp_fc++;
        n_chk++;
        if (s_tvalid !== 1'b0 || s_fc !== 16'(exp_fc)) begin
            n_fail++;
            $display("FAIL partial_one_cycle: got tvalid %b fc %0d, required 0 and %0d", s_tvalid, s_fc, exp_fc);
        end
    endtask

    task automatic test_sticky_user();
        logic [7:0] d[16];
        clear_a();
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) send_a(d[i], i == 9, i == 2);
        repeat (2) @(posedge clk); #1;
        exp_fc++; exp_es++;
        n_chk++;
        if (wq_data.size() != 2) begin
            n_fail++;
            $display("FAIL sticky_words: got %0d words, required 2", wq_data.size());
        end else begin
            n_chk++;
            if ({wq_data[0], wq_keep[0], wq_us[0], wq_un[0]} !== {pack8(d, 0, 8), 8'hFF, 2'b00}) begin
                n_fail++;
                $display("FAIL sticky_w0: got %h k%h us%b un%b, required %h kFF us0 un0", wq_data[0], wq_keep[0], wq_us[0], wq_un[0], pack8(d, 0, 8));
            end
            n_chk++;
            if ({wq_data[1], wq_keep[1], wq_last[1], wq_us[1], wq_un[1]} !== {pack8(d, 8, 2), 8'h03, 3'b110}) begin
                n_fail++;
                $display("FAIL sticky_w1: got %h k%h l%b us%b un%b, required %h k03 l1 us1 un0", wq_data[1], wq_keep[1], wq_last[1], wq_us[1], wq_un[1], pack8(d, 8, 2));
            end
        end
        n_chk++;
        if (s_ec !== 16'(exp_es) || n_ec !== 16'(exp_en)) begin
            n_fail++;
            $display("FAIL sticky_err_count: got sticky %0d last-only %0d, required %0d and %0d", s_ec, n_ec, exp_es, exp_en);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d[16];
        int bad = 0;
        clear_a();
        for (int i = 0; i < 16; i++) d[i] = 8'h20 + 8'(i);
        a_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_a(d[i], 1'b0, 1'b0);
        a_data = d[8]; a_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (a_rdy_s !== 1'b0 || {s_tvalid, s_tdata, s_tkeep, s_tlast} !== {1'b1, pack8(d, 0, 8), 8'hFF, 1'b0}) bad++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d stalled cycles with mac_tready=1 or changed output, required 0", bad);
        end
        a_tready = 1'b1;
        for (int i = 8; i < 12; i++) send_a(d[i], i == 11, 1'b0);
        repeat (2) @(posedge clk); #1;
        exp_fc++;
        n_chk++;
        if (wq_data.size() != 2) begin
            n_fail++;
            $display("FAIL stall_words: got %0d words, required 2", wq_data.size());
        end else begin
            n_chk++;
            if ({wq_data[0], wq_keep[0], wq_data[1], wq_keep[1], wq_last[1]} !== {pack8(d, 0, 8), 8'hFF, pack8(d, 8, 4), 8'h0F, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_data: got %h/%h %h/%h l%b, required %h/FF %h/0F l1", wq_data[0], wq_keep[0], wq_data[1], wq_keep[1], wq_last[1], pack8(d, 0, 8), pack8(d, 8, 4));
            end
        end
        n_chk++;
        if (s_fc !== 16'(exp_fc)) begin
            n_fail++;
            $display("FAIL stall_frame_count: got %0d, required %0d", s_fc, exp_fc);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d[16];
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) send_a(8'hE0 + 8'(i), 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        exp_fc = 0; exp_es = 0; exp_en = 0;
        n_chk++;
        if ({s_fc, s_ec, s_tvalid} !== 33'd0) begin
            n_fail++;
            $display("FAIL async_reset: got fc %0d ec %0d tvalid %b mid-cycle, required 0 0 0", s_fc, s_ec, s_tvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_a();
        for (int i = 0; i < 8; i++) send_a(d[i], i == 7, 1'b0);
        repeat (2) @(posedge clk); #1;
        exp_fc++;
        n_chk++;
        if (wq_data.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_words: got %0d words, required 1", wq_data.size());
        end else begin
            n_chk++;
            if ({wq_data[0], wq_keep[0], wq_last[0], wq_us[0]} !== {pack8(d, 0, 8), 8'hFF, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_mid_word: got %h k%h l%b u%b, required %h kFF l1 u0", wq_data[0], wq_keep[0], wq_last[0], wq_us[0], pack8(d, 0, 8));
            end
        end
        n_chk++;
        if (s_fc !== 16'(exp_fc) || s_ec !== 16'(exp_es)) begin
            n_fail++;
            $display("FAIL reset_mid_counters: got fc %0d ec %0d, required %0d %0d", s_fc, s_ec, exp_fc, exp_es);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] exp_bytes[$];
        int         exp_lens[$];
        logic       exp_user[$];
        int         exp_err = 0;
        int         nframes = 1000;
        int         len_bad = 0, byte_bad = 0, user_bad = 0, w = 0;
        bit         done = 0;
        got_b_bytes.delete(); got_b_lens.delete(); got_b_user.delete();
        cur_b_len = 0; keep_err = 0; stab_err = 0;
        fork
            begin
                for (int f = 0; f < nframes; f++) begin
                    int   len = $urandom_range(1, 64);
                    logic fu = 1'b0;
                    for (int i = 0; i < len; i++) begin
                        logic [7:0] d = 8'($urandom);
                        logic       u = ($urandom_range(0, 31) == 0);
                        while ($urandom_range(0, 7) == 0) begin
                            @(posedge clk); #1;
                        end
                        exp_bytes.push_back(d);
                        fu = fu | u;
                        send_b(d, i == len - 1, u);
                    end
                    exp_lens.push_back(len);
                    exp_user.push_back(fu);
                    if (fu) exp_err++;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    b_tready = ($urandom_range(0, 7) != 0);
                end
                b_tready = 1'b1;
            end
        join
        while (got_b_lens.size() < nframes && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (2) @(posedge clk); #1;
        n_chk++;
        if (got_b_lens.size() != nframes || got_b_bytes.size() != exp_bytes.size()) begin
            n_fail++;
            $display("FAIL rand_totals: got %0d frames %0d bytes, required %0d frames %0d bytes", got_b_lens.size(), got_b_bytes.size(), nframes, exp_bytes.size());
        end
        for (int i = 0; i < nframes && i < got_b_lens.size(); i++) begin
            if (got_b_lens[i] != exp_lens[i]) len_bad++;
            if (got_b_user[i] !== exp_user[i]) user_bad++;
        end
        for (int i = 0; i < exp_bytes.size() && i < got_b_bytes.size(); i++)
            if (got_b_bytes[i] !== exp_bytes[i]) byte_bad++;
        n_chk++;
        if (len_bad != 0) begin
            n_fail++;
            $display("FAIL rand_frame_lengths: %0d frames with wrong length, required 0", len_bad);
        end
        n_chk++;
        if (byte_bad != 0) begin
            n_fail++;
            $display("FAIL rand_byte_stream: %0d bytes differ from scoreboard, required 0", byte_bad);
        end
        n_chk++;
        if (user_bad != 0) begin
            n_fail++;
            $display("FAIL rand_frame_tuser: %0d frames with wrong tuser, required 0", user_bad);
        end
        n_chk++;
        if (keep_err != 0 || stab_err != 0) begin
            n_fail++;
            $display("FAIL rand_protocol: %0d keep/lane errors %0d stall changes, required 0 0", keep_err, stab_err);
        end
        n_chk++;
        if (q_fc !== 16'(nframes) || q_ec !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL rand_counters: got fc %0d ec %0d, required %0d %0d", q_fc, q_ec, nframes, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_partial();
        test_sticky_user();
        test_backpressure();
        test_reset_mid_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
